// File: rtl/video_mode_switch.sv
// Video-mode selector: filters the requested mode code, maps it onto the mode table and
// sequences a glitch-free switch (frame boundary -> blank -> PLL handshake -> settle).
module video_mode_switch #(
    parameter int unsigned                        NUM_MODES     = 3,
    parameter int unsigned                        CODE_WIDTH    = 8,
    parameter logic [NUM_MODES*CODE_WIDTH-1:0]    MODE_CODES    = {8'h03, 8'h02, 8'h01},
    parameter int unsigned                        DEFAULT_MODE  = 2,
    parameter int unsigned                        STABLE_CYCLES = 16,
    parameter int unsigned                        SETTLE_CYCLES = 64,
    parameter int unsigned                        ACK_TIMEOUT   = 4096,
    localparam int unsigned                       IDXW = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [CODE_WIDTH-1:0] data_in,
    input  logic                  frame_end,
    input  logic                  reconf_ack,
    output logic [IDXW-1:0]       mode_idx,
    output logic [IDXW-1:0]       pending_idx,
    output logic                  video_enable,
    output logic                  reconf_req,
    output logic                  busy,
    output logic                  mode_change,
    output logic                  reconf_err
);

    localparam logic [7:0]      STAB_MAX    = 8'(STABLE_CYCLES);
    localparam logic [15:0]     ACK_LAST    = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0]     SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [IDXW-1:0] DEF_IDX     = IDXW'(DEFAULT_MODE);

    typedef enum logic [1:0] {StRun, StDrain, StReconf, StSettle} state_e;

    state_e                state_q, state_d;
    logic [CODE_WIDTH-1:0] data_q;
    logic [7:0]            stab_cnt_q, stab_cnt_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [IDXW-1:0]       mode_idx_q, mode_idx_d;
    logic [IDXW-1:0]       pending_idx_q, pending_idx_d;
    logic                  video_enable_q, video_enable_d;
    logic                  reconf_req_q, reconf_req_d;
    logic                  busy_q, busy_d;
    logic                  mode_change_q, mode_change_d;
    logic                  reconf_err_q, reconf_err_d;
    logic                  acked_q, acked_d;
    logic                  code_stable;
    logic                  lut_valid;
    logic [IDXW-1:0]       lut_idx;

    // Stability counter: restarts on any code change, saturates once the code has settled.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (data_in != data_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end
    end

    assign code_stable = (stab_cnt_q == STAB_MAX);

    // Input filter registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_q     <= '0;
            stab_cnt_q <= '0;
        end else begin
            data_q     <= data_in;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    // Table lookup on the filtered code; the lowest matching entry wins.
    always_comb begin
        lut_valid = 1'b0;
        lut_idx   = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (!lut_valid && (data_q == MODE_CODES[i*CODE_WIDTH +: CODE_WIDTH])) begin
                lut_valid = 1'b1;
                lut_idx   = IDXW'(i);
            end
        end
    end

    // Switch sequencer next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mode_idx_d     = mode_idx_q;
        pending_idx_d  = pending_idx_q;
        video_enable_d = video_enable_q;
        reconf_req_d   = reconf_req_q;
        busy_d         = busy_q;
        mode_change_d  = 1'b0;
        reconf_err_d   = reconf_err_q;
        acked_d        = acked_q;
        unique case (state_q)
            StRun: begin
                if (code_stable && lut_valid && (lut_idx != mode_idx_q)) begin
                    pending_idx_d = lut_idx;
                    busy_d        = 1'b1;
                    state_d       = StDrain;
                end
            end
            StDrain: begin
                // Blank and request reconfiguration only at a frame boundary.
                if (frame_end) begin
                    video_enable_d = 1'b0;
                    reconf_req_d   = 1'b1;
                    cnt_d          = '0;
                    state_d        = StReconf;
                end
            end
            StReconf: begin
                if (reconf_ack) begin
                    mode_idx_d   = pending_idx_q;
                    reconf_req_d = 1'b0;
                    acked_d      = 1'b1;
                    cnt_d        = '0;
                    state_d      = StSettle;
                end else if (cnt_q == ACK_LAST) begin
                    // Give up on the PLL; keep the old mode but still settle before video.
                    reconf_req_d = 1'b0;
                    reconf_err_d = 1'b1;
                    acked_d      = 1'b0;
                    cnt_d        = '0;
                    state_d      = StSettle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    video_enable_d = 1'b1;
                    busy_d         = 1'b0;
                    mode_change_d  = acked_q;
                    state_d        = StRun;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= StRun;
            cnt_q          <= '0;
            mode_idx_q     <= DEF_IDX;
            pending_idx_q  <= DEF_IDX;
            video_enable_q <= 1'b1;
            reconf_req_q   <= 1'b0;
            busy_q         <= 1'b0;
            mode_change_q  <= 1'b0;
            reconf_err_q   <= 1'b0;
            acked_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mode_idx_q     <= mode_idx_d;
            pending_idx_q  <= pending_idx_d;
            video_enable_q <= video_enable_d;
            reconf_req_q   <= reconf_req_d;
            busy_q         <= busy_d;
            mode_change_q  <= mode_change_d;
            reconf_err_q   <= reconf_err_d;
            acked_q        <= acked_d;
        end
    end

    assign mode_idx     = mode_idx_q;
    assign pending_idx  = pending_idx_q;
    assign video_enable = video_enable_q;
    assign reconf_req   = reconf_req_q;
    assign busy         = busy_q;
    assign mode_change  = mode_change_q;
    assign reconf_err   = reconf_err_q;

endmodule

// File: tb/tb_video_mode_switch.sv
// Bench for video_mode_switch: vector table, directed corner sequences and a randomized run
// compared cycle by cycle against a timestamp-based reference model.
module tb_video_mode_switch;

    localparam int unsigned S   = 4;
    localparam int unsigned SET = 8;
    localparam int unsigned TMO = 16;
    localparam logic [7:0]  CODES [3] = '{8'h01, 8'h02, 8'h03};

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] data_in;
    logic       frame_end;
    logic       reconf_ack;
    logic [1:0] mode_idx;
    logic [1:0] pending_idx;
    logic       video_enable;
    logic       reconf_req;
    logic       busy;
    logic       mode_change;
    logic       reconf_err;

    always #5 clock = ~clock;

    video_mode_switch #(
        .NUM_MODES    (3),
        .CODE_WIDTH   (8),
        .MODE_CODES   ({8'h03, 8'h02, 8'h01}),
        .DEFAULT_MODE (2),
        .STABLE_CYCLES(S),
        .SETTLE_CYCLES(SET),
        .ACK_TIMEOUT  (TMO)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .data_in     (data_in),
        .frame_end   (frame_end),
        .reconf_ack  (reconf_ack),
        .mode_idx    (mode_idx),
        .pending_idx (pending_idx),
        .video_enable(video_enable),
        .reconf_req  (reconf_req),
        .busy        (busy),
        .mode_change (mode_change),
        .reconf_err  (reconf_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit req_seen, busy_seen, mc_seen;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, actual, expected);
    endtask

    // Reference model: phase plus entry timestamps, filter as a window of recent samples.
    int         m_phase;  // 0 run, 1 drain, 2 reconf, 3 settle
    int         m_mode, m_pend, m_entry, m_cyc;
    bit         m_acked, m_err, m_mc;
    logic [7:0] m_hist [$];

    function automatic void model_reset();
        m_hist  = {};
        m_hist.push_back(8'h00);
        m_phase = 0;
        m_mode  = 2;
        m_pend  = 2;
        m_entry = 0;
        m_cyc   = 0;
        m_acked = 0;
        m_err   = 0;
        m_mc    = 0;
    endfunction

    function automatic void lookup(input logic [7:0] c, output bit v, output int idx);
        v   = 0;
        idx = 0;
        for (int k = 2; k >= 0; k--) begin
            if (CODES[k] == c) begin
                v   = 1;
                idx = k;
            end
        end
    endfunction

    function automatic void model_edge(input logic [7:0] din, input logic fe, input logic ack);
        bit stable, v;
        int idx;
        stable = (m_hist.size() == S + 1);
        for (int k = 1; k < m_hist.size(); k++) if (m_hist[k] != m_hist[0]) stable = 0;
        lookup(m_hist[m_hist.size()-1], v, idx);
        m_mc = 0;
        case (m_phase)
            0: if (stable && v && idx != m_mode) begin m_pend = idx; m_phase = 1; end
            1: if (fe) begin m_phase = 2; m_entry = m_cyc; end
            2: begin
                if (ack) begin
                    m_mode = m_pend; m_acked = 1; m_phase = 3; m_entry = m_cyc;
                end else if (m_cyc - m_entry >= TMO) begin
                    m_err = 1; m_acked = 0; m_phase = 3; m_entry = m_cyc;
                end
            end
            default: if (m_cyc - m_entry >= SET) begin m_phase = 0; m_mc = m_acked; end
        endcase
        m_hist.push_back(din);
        if (m_hist.size() > S + 1) void'(m_hist.pop_front());
        m_cyc++;
    endfunction

    function automatic int model_vec();
        logic ven, req, bsy;
        ven = (m_phase <= 1);
        req = (m_phase == 2);
        bsy = (m_phase != 0);
        return int'({2'(m_mode), 2'(m_pend), ven, req, bsy, m_mc, m_err});
    endfunction

    // One clock edge: advance the model with the inputs the DUT sees, then compare.
    task automatic step();
        @(posedge clock);
        model_edge(data_in, frame_end, reconf_ack);
        #1;
        if (reconf_req) req_seen = 1;
        if (busy) busy_seen = 1;
        if (mode_change) mc_seen = 1;
        check("model", int'({mode_idx, pending_idx, video_enable, reconf_req, busy, mode_change,
                             reconf_err}), model_vec());
    endtask

    typedef struct {
        logic [7:0] din;
        logic       fe;
        logic       ack;
        int         reps;
        int         mode;
        int         pend;
        int         ven;
        int         req;
        int         bsy;
        int         mc;
        int         err;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 03 -> 01 switch: filter latency, frame boundary, ack after 5 cycles, settle of 8.
        vecs.push_back('{8'h03, 1'b0, 1'b0, 10, 2, 2, 1, 0, 0, 0, 0});
        vecs.push_back('{8'h01, 1'b0, 1'b0,  5, 2, 2, 1, 0, 0, 0, 0});
        vecs.push_back('{8'h01, 1'b0, 1'b0,  1, 2, 0, 1, 0, 1, 0, 0});
        vecs.push_back('{8'h01, 1'b0, 1'b0,  4, 2, 0, 1, 0, 1, 0, 0});
        vecs.push_back('{8'h01, 1'b1, 1'b0,  1, 2, 0, 0, 1, 1, 0, 0});
        vecs.push_back('{8'h01, 1'b0, 1'b0,  4, 2, 0, 0, 1, 1, 0, 0});
        vecs.push_back('{8'h01, 1'b0, 1'b1,  1, 0, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{8'h01, 1'b0, 1'b0,  7, 0, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{8'h01, 1'b0, 1'b0,  1, 0, 0, 1, 0, 0, 1, 0});
        vecs.push_back('{8'h01, 1'b0, 1'b0,  1, 0, 0, 1, 0, 0, 0, 0});

        resetn     = 1'b0;
        data_in    = 8'h03;
        frame_end  = 1'b0;
        reconf_ack = 1'b0;
        model_reset();
        #12;
        check("rst.mode", mode_idx, 2);
        check("rst.pend", pending_idx, 2);
        check("rst.ven", video_enable, 1);
        check("rst.req", reconf_req, 0);
        check("rst.busy", busy, 0);
        check("rst.mc", mode_change, 0);
        check("rst.err", reconf_err, 0);
        resetn = 1'b1;

        // Idle with the default code: nothing happens.
        req_seen = 0;
        repeat (40) step();
        check("idle.mode", mode_idx, 2);
        check("idle.busy", busy, 0);
        check("idle.req_seen", int'(req_seen), 0);

        // Glitching code never becomes stable; unknown code is ignored.
        busy_seen = 0;
        for (int c = 0; c < 50; c++) begin
            data_in = (((c / 3) % 2) == 1) ? 8'h02 : 8'h03;
            step();
        end
        data_in = 8'h03;
        repeat (20) step();
        check("glitch.busy_seen", int'(busy_seen), 0);
        check("glitch.mode", mode_idx, 2);
        data_in = 8'h7F;
        repeat (100) step();
        check("unknown.busy_seen", int'(busy_seen), 0);
        check("unknown.mode", mode_idx, 2);

        foreach (vecs[i]) begin
            data_in    = vecs[i].din;
            frame_end  = vecs[i].fe;
            reconf_ack = vecs[i].ack;
            repeat (vecs[i].reps) step();
            frame_end  = 1'b0;
            reconf_ack = 1'b0;
            check($sformatf("vec%0d.mode", i), mode_idx, vecs[i].mode);
            check($sformatf("vec%0d.pend", i), pending_idx, vecs[i].pend);
            check($sformatf("vec%0d.ven", i), video_enable, vecs[i].ven);
            check($sformatf("vec%0d.req", i), reconf_req, vecs[i].req);
            check($sformatf("vec%0d.busy", i), busy, vecs[i].bsy);
            check($sformatf("vec%0d.mc", i), mode_change, vecs[i].mc);
            check($sformatf("vec%0d.err", i), reconf_err, vecs[i].err);
        end

        // Code changes mid-RECONF: first switch completes, second starts right after RUN.
        data_in = 8'h03;
        repeat (5) step();
        check("chg.busy_early", busy, 0);
        step();
        check("chg.busy", busy, 1);
        check("chg.pend", pending_idx, 2);
        repeat (2) step();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        check("chg.req", reconf_req, 1);
        check("chg.ven_low", video_enable, 0);
        repeat (2) step();
        data_in = 8'h02;
        repeat (2) step();
        reconf_ack = 1'b1;
        step();
        reconf_ack = 1'b0;
        check("chg.mode_on_ack", mode_idx, 2);
        check("chg.req_drop", reconf_req, 0);
        repeat (7) step();
        check("chg.settle_ven", video_enable, 0);
        step();
        check("chg.ven_back", video_enable, 1);
        check("chg.mc", mode_change, 1);
        check("chg.busy_low", busy, 0);
        step();
        check("chg.second_busy", busy, 1);
        check("chg.second_pend", pending_idx, 1);
        check("chg.mc_pulse", mode_change, 0);
        frame_end = 1'b1;
        step();
        frame_end  = 1'b0;
        reconf_ack = 1'b1;
        step();
        reconf_ack = 1'b0;
        check("chg.second_mode", mode_idx, 1);
        repeat (SET) step();
        check("chg.second_done", busy, 0);

        // Ack timeout: request held TMO cycles, sticky error, mode unchanged.
        data_in = 8'h03;
        repeat (6) step();
        check("tmo.busy", busy, 1);
        mc_seen   = 0;
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        check("tmo.req", reconf_req, 1);
        repeat (TMO - 1) step();
        check("tmo.req_held", reconf_req, 1);
        check("tmo.err_early", reconf_err, 0);
        step();
        check("tmo.req_drop", reconf_req, 0);
        check("tmo.err", reconf_err, 1);
        check("tmo.mode", mode_idx, 1);
        check("tmo.pend", pending_idx, 2);
        data_in = 8'h02;
        repeat (SET - 1) step();
        check("tmo.settle_ven", video_enable, 0);
        step();
        check("tmo.ven_back", video_enable, 1);
        check("tmo.busy_low", busy, 0);
        busy_seen = 0;
        repeat (10) step();
        check("tmo.no_retry", int'(busy_seen), 0);
        check("tmo.err_sticky", reconf_err, 1);
        check("tmo.pend_kept", pending_idx, 2);
        check("tmo.mc_seen", int'(mc_seen), 0);

        // Asynchronous reset in the middle of the handshake.
        data_in = 8'h03;
        repeat (6) step();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        repeat (3) step();
        check("mid.req", reconf_req, 1);
        #2 resetn = 1'b0;
        #1;
        check("mid.req", reconf_req, 0);
        check("mid.ven", video_enable, 1);
        check("mid.mode", mode_idx, 2);
        check("mid.pend", pending_idx, 2);
        check("mid.err", reconf_err, 0);
        check("mid.busy", busy, 0);
        model_reset();
        #1 resetn = 1'b1;

        // Randomized run against the model.
        begin
            int hold = 0;
            logic [7:0] pool [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F};
            for (int c = 0; c < 3000; c++) begin
                if (hold == 0) begin
                    data_in = pool[$urandom_range(0, 4)];
                    hold    = $urandom_range(1, 14);
                end
                hold--;
                frame_end  = ($urandom_range(0, 7) == 0);
                reconf_ack = ($urandom_range(0, 11) == 0);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
